// File: rtl/div_arbiter_pkg.sv
// Shared types and defaults for the divider arbiter and the pixel stages that feed it.
package div_arbiter_pkg;

    localparam int DEFAULT_NUM_REQ        = 4;
    localparam int DEFAULT_DIVIDEND_WIDTH = 16;
    localparam int DEFAULT_DIVISOR_WIDTH  = 8;
    localparam int DEFAULT_TAG_DEPTH      = 8;

    // Id width sized for the largest supported requester count (8).
    localparam int MAX_REQ      = 8;
    localparam int REQ_ID_WIDTH = $clog2(MAX_REQ);

    typedef logic [REQ_ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        req_id_t id;
        logic    div_zero;
    } tag_t;

    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_BUSY = 2'd1;
    localparam logic [1:0] SLOT_DONE = 2'd2;

    function automatic req_id_t next_id(input req_id_t id, input int num_req);
        if (int'(id) >= num_req - 1) begin
            next_id = {REQ_ID_WIDTH{1'b0}};
        end else begin
            next_id = id + req_id_t'(1);
        end
    endfunction

endpackage

// File: rtl/div.sv
// Pipelined restoring divider: one quotient bit per stage, accepts an operation every cycle,
// valid_in-to-valid_out latency of DIVIDEND_WIDTH cycles, results in order.
module div #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      valid_out,
    output logic [DIVIDEND_WIDTH-1:0] quotient
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;

    function automatic logic fits(input logic [VW-1:0] rem, input logic msb, input logic [VW-1:0] dvs);
        fits = ({rem, msb} >= {1'b0, dvs});
    endfunction

    // Remainder stays below the divisor, so the subtraction is exact modulo 2^VW.
    function automatic logic [VW-1:0] next_rem(input logic [VW-1:0] rem, input logic msb, input logic [VW-1:0] dvs);
        logic [VW:0] shifted;
        shifted = {rem, msb};
        if (shifted >= {1'b0, dvs}) begin
            next_rem = shifted[VW-1:0] - dvs;
        end else begin
            next_rem = shifted[VW-1:0];
        end
    endfunction

    logic [VW-1:0] rem_r [DW-1];
    logic [VW-1:0] dvs_r [DW-1];
    logic [DW-1:0] num_r [DW-1];
    logic [DW-2:0] vld_r;
    logic          valid_out_r;
    logic [DW-1:0] quotient_r;

    // Each stage shifts one dividend bit into the remainder and one quotient bit into num.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DW - 1; k++) begin
                rem_r[k] <= {VW{1'b0}};
                dvs_r[k] <= {VW{1'b0}};
                num_r[k] <= {DW{1'b0}};
            end
            vld_r       <= {(DW-1){1'b0}};
            valid_out_r <= 1'b0;
            quotient_r  <= {DW{1'b0}};
        end else begin
            rem_r[0] <= next_rem({VW{1'b0}}, dividend[DW-1], divisor);
            num_r[0] <= {dividend[DW-2:0], fits({VW{1'b0}}, dividend[DW-1], divisor)};
            dvs_r[0] <= divisor;
            vld_r[0] <= valid_in;
            for (int k = 1; k < DW - 1; k++) begin
                rem_r[k] <= next_rem(rem_r[k-1], num_r[k-1][DW-1], dvs_r[k-1]);
                num_r[k] <= {num_r[k-1][DW-2:0], fits(rem_r[k-1], num_r[k-1][DW-1], dvs_r[k-1])};
                dvs_r[k] <= dvs_r[k-1];
                vld_r[k] <= vld_r[k-1];
            end
            valid_out_r <= vld_r[DW-2];
            quotient_r  <= {num_r[DW-2][DW-2:0], fits(rem_r[DW-2], num_r[DW-2][DW-1], dvs_r[DW-2])};
        end
    end

    assign valid_out = valid_out_r;
    assign quotient  = quotient_r;

endmodule

// File: rtl/div_arbiter_checker.sv
// Simulation-only protocol checks for the divider arbiter.
module div_arbiter_checker #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input logic                           clock,
    input logic                           reset,
    input logic                           div_valid,
    input logic                           fifo_empty,
    input logic [$clog2(TAG_DEPTH+1)-1:0] fifo_count,
    input logic [NUM_REQ-1:0]             req_ready
);

    // A divider result with no outstanding tag has no owner and is dropped.
    assert property (@(posedge clock) disable iff (reset) !(div_valid && fifo_empty));

    assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));

    assert property (@(posedge clock) disable iff (reset) int'(fifo_count) <= TAG_DEPTH);

endmodule

// File: rtl/div_arbiter_tag_fifo.sv
// Synchronous FIFO of result tags; tells the arbiter which requester owns each divider result.
module tag_fifo
    import div_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_TAG_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  tag_t                       push_tag,
    input  logic                       pop,
    output tag_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    tag_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, wrapping pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{id: {REQ_ID_WIDTH{1'b0}}, div_zero: 1'b0};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_tag;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one pipelined divider among NUM_REQ requesters, one op in flight each,
// with results routed back to per-requester response registers by a tag FIFO.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEFAULT_DIVISOR_WIDTH,
    parameter int TAG_DEPTH      = DEFAULT_TAG_DEPTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [NUM_REQ*DIVIDEND_WIDTH-1:0] resp_quotient,
    output logic [NUM_REQ-1:0]                resp_div_zero,
    output logic                              busy
);

    localparam int DW    = DIVIDEND_WIDTH;
    localparam int VW    = DIVISOR_WIDTH;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [1:0]            state_r [NUM_REQ];
    req_id_t               rr_ptr_r;
    logic [NUM_REQ*DW-1:0] quotient_r;
    logic [NUM_REQ-1:0]    div_zero_r;
    logic                  div_start_r;
    logic [DW-1:0]         div_dividend_r;
    logic [VW-1:0]         div_divisor_r;

    logic             found_s;
    logic             accept_s;
    req_id_t          win_id_s;
    int               idx_s;
    logic [DW-1:0]    acc_dividend_s;
    logic [VW-1:0]    acc_divisor_s;
    tag_t             push_tag_s;
    tag_t             head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             div_valid_s;
    logic [DW-1:0]    div_quotient_s;
    logic             ret_valid_s;

    // Round-robin search from rr_ptr over requesters that are valid and idle.
    always_comb begin
        found_s  = 1'b0;
        win_id_s = {REQ_ID_WIDTH{1'b0}};
        idx_s    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && req_valid[idx_s] && (state_r[idx_s] == SLOT_IDLE)) begin
                found_s  = 1'b1;
                win_id_s = req_id_t'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        accept_s = found_s && !fifo_full_s && !reset;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept_s && (win_id_s == req_id_t'(i));
        end
        acc_dividend_s = req_dividend[int'(win_id_s)*DW +: DW];
        acc_divisor_s  = req_divisor[int'(win_id_s)*VW +: VW];
        push_tag_s     = '{id: win_id_s, div_zero: (acc_divisor_s == {VW{1'b0}})};
    end

    assign ret_valid_s = div_valid_s && !fifo_empty_s;

    // Slot FSMs, pointer update, divider issue register and response capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_r[i] <= SLOT_IDLE;
            end
            rr_ptr_r       <= {REQ_ID_WIDTH{1'b0}};
            quotient_r     <= {(NUM_REQ*DW){1'b0}};
            div_zero_r     <= {NUM_REQ{1'b0}};
            div_start_r    <= 1'b0;
            div_dividend_r <= {DW{1'b0}};
            div_divisor_r  <= {VW{1'b0}};
        end else begin
            div_start_r <= accept_s;
            if (accept_s) begin
                div_dividend_r <= acc_dividend_s;
                div_divisor_r  <= acc_divisor_s;
                rr_ptr_r       <= next_id(win_id_s, NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case (state_r[i])
                    SLOT_IDLE: if (req_ready[i]) state_r[i] <= SLOT_BUSY;
                    SLOT_BUSY: begin
                        if (ret_valid_s && (head_s.id == req_id_t'(i))) begin
                            state_r[i] <= SLOT_DONE;
                            quotient_r[i*DW +: DW] <= head_s.div_zero ? {DW{1'b1}} : div_quotient_s;
                            div_zero_r[i] <= head_s.div_zero;
                        end
                    end
                    SLOT_DONE: if (resp_ready[i]) state_r[i] <= SLOT_IDLE;
                    default:   state_r[i] <= SLOT_IDLE;
                endcase
            end
        end
    end

    // Response outputs decode registered slot state only.
    always_comb begin
        busy = !fifo_empty_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (state_r[i] == SLOT_DONE);
            busy          = busy || (state_r[i] != SLOT_IDLE);
        end
    end

    assign resp_quotient = quotient_r;
    assign resp_div_zero = div_zero_r;

    tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (accept_s),
        .push_tag (push_tag_s),
        .pop      (div_valid_s),
        .head     (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    div #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) u_div (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (div_start_r),
        .dividend  (div_dividend_r),
        .divisor   (div_divisor_r),
        .valid_out (div_valid_s),
        .quotient  (div_quotient_s)
    );

    div_arbiter_checker #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) u_checker (
        .clock      (clock),
        .reset      (reset),
        .div_valid  (div_valid_s),
        .fifo_empty (fifo_empty_s),
        .fifo_count (fifo_count_s),
        .req_ready  (req_ready)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter against a cycle-level behavioural model of the requester protocol.
module tb_div_arbiter;

    localparam int N        = 4;
    localparam int RESP_LAT = 18;  // divider latency (16) + issue register + response register

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = 4'b0000;
    logic [N-1:0]  req_ready;
    logic [63:0]   req_dividend = 64'd0;
    logic [31:0]   req_divisor = 32'd0;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready = 4'b0000;
    logic [63:0]   resp_quotient;
    logic [N-1:0]  resp_div_zero;
    logic          busy;

    div_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_quotient (resp_quotient),
        .resp_div_zero (resp_div_zero),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 = free, 1 = waiting for result, 2 = result held for the requester.
    int          m_st [N];
    logic [15:0] m_q [N];
    logic        m_dz [N];
    int          m_due [N];
    int          m_ptr;
    int          cyc;
    int          acc_cnt [N];
    int          done_cnt [N];

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = 4'b0000;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i] && m_st[i] == 0) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_resp_valid();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_st[i] == 2);
        return r;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++) if (m_st[i] != 0) b = 1'b1;
        return b;
    endfunction

    function automatic int total_acc();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) t += acc_cnt[i];
        return t;
    endfunction

    function automatic logic all_free();
        logic f;
        f = 1'b1;
        for (int i = 0; i < N; i++) if (m_st[i] != 0) f = 1'b0;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_q[i] = 16'd0; m_dz[i] = 1'b0; m_due[i] = 0;
            acc_cnt[i] = 0; done_cnt[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [7:0] b);
        req_dividend[i*16 +: 16] = a;
        req_divisor[i*8 +: 8]    = b;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic tick();
        logic [N-1:0] r;
        logic [15:0]  a;
        logic [7:0]   b;
        r = exp_ready();
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                a = req_dividend[i*16 +: 16];
                b = req_divisor[i*8 +: 8];
                m_st[i]  = 1;
                m_due[i] = cyc + RESP_LAT;
                m_q[i]   = (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
                m_dz[i]  = (b == 8'd0);
                acc_cnt[i]++;
                m_ptr = (i + 1) % N;
            end else if (m_st[i] == 2 && resp_ready[i]) begin
                m_st[i] = 0;
                done_cnt[i]++;
            end
        end
        @(negedge clock);
        cyc++;
        for (int i = 0; i < N; i++) if (m_st[i] == 1 && m_due[i] == cyc) m_st[i] = 2;
    endtask

    task automatic reset_dut();
        req_valid = 4'b0000; resp_ready = 4'b0000; reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = 4'b1111; resp_ready = 4'b0000; reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        vectors++; if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid); end
        vectors++; if (resp_quotient !== 64'd0 || resp_div_zero !== 4'b0000) begin miscompares++; $display("FAIL reset_resp_data got %h/%b want 0/0000", resp_quotient, resp_div_zero); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        req_valid = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_single();
        set_op(0, 16'd1000, 8'd7);
        req_valid = 4'b0001;
        for (int c = 0; c < RESP_LAT + 3; c++) begin
            if (c == 1) req_valid = 4'b0000;
            #1;
            vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("FAIL single_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL single_resp_valid c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            if (m_st[0] == 2) begin
                vectors++;
                if (resp_quotient[15:0] !== 16'd142 || resp_div_zero[0] !== 1'b0) begin
                    miscompares++; $display("FAIL single_quotient got %0d/%b want 142/0", resp_quotient[15:0], resp_div_zero[0]);
                end
            end
            tick();
        end
        resp_ready = 4'b0001;
        #1;
        vectors++; if (resp_valid !== 4'b0001) begin miscompares++; $display("FAIL single_held got %b want 0001", resp_valid); end
        tick();
        resp_ready = 4'b0000;
        #1;
        vectors++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL single_release got %b/%b want 0000/0", resp_valid, busy); end
    endtask

    task automatic test_div_zero();
        set_op(2, 16'd55, 8'd0);
        req_valid = 4'b0100;
        for (int c = 0; c < RESP_LAT + 2; c++) begin
            if (c == 1) req_valid = 4'b0000;
            #1;
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL dz_resp_valid c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            tick();
        end
        #1;
        vectors++;
        if (resp_valid !== 4'b0100 || resp_quotient[47:32] !== 16'hFFFF || resp_div_zero !== 4'b0100) begin
            miscompares++; $display("FAIL dz_result got %b/%h/%b want 0100/ffff/0100", resp_valid, resp_quotient[47:32], resp_div_zero);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = 4'b0000;
    endtask

    task automatic test_contention();
        reset_dut();
        set_op(1, 16'd90, 8'd9);
        set_op(3, 16'd200, 8'd8);
        req_valid = 4'b1010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL cont_first got %b want 0010", req_ready); end
        tick();
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL cont_second got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < RESP_LAT + 2; c++) begin
            #1;
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL cont_resp_valid c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            if (m_st[1] == 2) begin
                vectors++; if (resp_quotient[31:16] !== 16'd10) begin miscompares++; $display("FAIL cont_q1 got %0d want 10", resp_quotient[31:16]); end
            end
            if (m_st[3] == 2) begin
                vectors++; if (resp_quotient[63:48] !== 16'd25) begin miscompares++; $display("FAIL cont_q3 got %0d want 25", resp_quotient[63:48]); end
            end
            tick();
        end
        resp_ready = 4'b1111;
        tick();
        resp_ready = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        reset_dut();
        resp_ready = 4'b1111;
        for (int c = 0; c < 5000; c++) begin
            if (total_acc() >= 100 && all_free()) break;
            if (total_acc() < 100) begin
                for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 8'($urandom_range(0, 255)));
                req_valid = 4'b1111;
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("FAIL fair_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
            if (exp_ready() != 4'b0000) begin
                want = 4'b0001 << (total_acc() % N);
                vectors++; if (req_ready !== want) begin miscompares++; $display("FAIL fair_rotation c=%0d got %b want %b", c, req_ready, want); end
            end
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL fair_resp_valid c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            for (int i = 0; i < N; i++) begin
                if (m_st[i] == 2) begin
                    vectors++;
                    if (resp_quotient[i*16 +: 16] !== m_q[i] || resp_div_zero[i] !== m_dz[i]) begin
                        miscompares++; $display("FAIL fair_result req=%0d got %h/%b want %h/%b", i, resp_quotient[i*16 +: 16], resp_div_zero[i], m_q[i], m_dz[i]);
                    end
                end
            end
            tick();
        end
        req_valid = 4'b0000;
        vectors++; if (!all_free() || busy !== 1'b0) begin miscompares++; $display("FAIL fair_drain got busy=%b want 0", busy); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (acc_cnt[i] != 25 || done_cnt[i] != 25) begin miscompares++; $display("FAIL fair_share req=%0d got %0d/%0d want 25/25", i, acc_cnt[i], done_cnt[i]); end
        end
    endtask

    task automatic test_hold();
        int held;
        int others_before;
        int others_after;
        held = 0;
        reset_dut();
        set_op(0, 16'd500, 8'd5);
        req_valid  = 4'b1111;
        resp_ready = 4'b1110;
        others_before = 0;
        for (int c = 0; c < 300 && held < 50; c++) begin
            for (int i = 1; i < N; i++) set_op(i, 16'($urandom), 8'($urandom_range(1, 255)));
            if (m_st[0] == 2 && held == 0) others_before = done_cnt[1] + done_cnt[2] + done_cnt[3];
            #1;
            vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("FAIL hold_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL hold_resp_valid c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            if (m_st[0] == 2) begin
                held++;
                vectors++;
                if (req_ready[0] !== 1'b0 || resp_quotient[15:0] !== 16'd100) begin
                    miscompares++; $display("FAIL hold_stable c=%0d got ready0=%b q=%0d want 0/100", c, req_ready[0], resp_quotient[15:0]);
                end
            end
            for (int i = 1; i < N; i++) begin
                if (m_st[i] == 2) begin
                    vectors++; if (resp_quotient[i*16 +: 16] !== m_q[i]) begin miscompares++; $display("FAIL hold_other req=%0d got %h want %h", i, resp_quotient[i*16 +: 16], m_q[i]); end
                end
            end
            tick();
        end
        others_after = done_cnt[1] + done_cnt[2] + done_cnt[3];
        vectors++; if (held < 50 || others_after <= others_before) begin miscompares++; $display("FAIL hold_progress got held=%0d others=%0d want 50/>0", held, others_after - others_before); end
        resp_ready = 4'b1111;
        #1;
        vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL hold_consume_ready got %b want 0", req_ready[0]); end
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 60 && !all_free(); c++) begin
            #1;
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL hold_drain c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            tick();
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        reset_dut();
        set_op(0, 16'd10, 8'd2);
        set_op(1, 16'd20, 8'd4);
        set_op(2, 16'd30, 8'd6);
        req_valid = 4'b0111;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) req_valid = 4'b0000;
            #1;
            vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("FAIL mid_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
            tick();
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || resp_quotient !== 64'd0 || resp_div_zero !== 4'b0000 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_outputs got %b/%b/%h/%b/%b want all 0", req_ready, resp_valid, resp_quotient, resp_div_zero, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        set_op(1, 16'd12, 8'd4);
        req_valid = 4'b0010;
        resp_ready = 4'b0000;
        for (int c = 0; c < RESP_LAT + 12; c++) begin
            if (c == 1) req_valid = 4'b0000;
            #1;
            vectors++; if (resp_valid !== exp_resp_valid()) begin miscompares++; $display("FAIL mid_stale c=%0d got %b want %b", c, resp_valid, exp_resp_valid()); end
            if (m_st[1] == 2) begin
                seen = 1'b1;
                vectors++; if (resp_quotient[31:16] !== 16'd3) begin miscompares++; $display("FAIL mid_result got %0d want 3", resp_quotient[31:16]); end
            end
            tick();
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL mid_no_result got none want resp_valid[1]"); end
    endtask

    initial begin
        model_reset();
        cyc = 0;
        test_reset();
        test_single();
        test_div_zero();
        test_contention();
        test_fairness();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
